// File: rtl/tbuf_bus_arbiter.sv
// Round-robin arbiter driving the enables of N tristate drivers on one shared net.
// At most one enable is high, with TURN_CYC all-off cycles between owners and an optional hold limit.
module tbuf_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         enb,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     bus_busy,
  output logic                     timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [HW-1:0]  hold_cnt;
  logic [3:0]     turn_cnt;

  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic           owner_drop;
  logic           at_max;
  logic [IDW-1:0] nxt_ptr;

  // First requester at or above the pointer, wrapping round to zero.
  always_comb begin
    logic [IDW-1:0] cand;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    win_vld = 1'b0;
    win_id  = ptr;
    cand    = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign owner_drop = ~req[gnt_id];
  assign at_max     = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
  assign nxt_ptr    = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);

  // NOTE: all state and registered outputs use non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      enb      <= '0;
      gnt_id   <= '0;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      turn_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        GRANT: begin
          if (owner_drop || at_max) begin
            enb      <= '0;
            ptr      <= nxt_ptr;
            turn_cnt <= 4'd1;
            // Only a still-requesting owner counts as forced off.
            timeout  <= at_max & ~owner_drop;
            state    <= TURN;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        IDLE, TURN: begin
          if (state == TURN && turn_cnt != 4'(TURN_CYC)) begin
            turn_cnt <= turn_cnt + 4'd1;
          end else if (win_vld) begin
            enb      <= N_REQ'(1) << win_id;
            gnt_id   <= win_id;
            hold_cnt <= HW'(1);
            bus_busy <= 1'b1;
            state    <= GRANT;
          end else begin
            bus_busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          enb      <= '0;
          bus_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Bench for tbuf_bus_arbiter: directed scenarios on a TURN_CYC=1/MAX_HOLD=16 instance,
// randomized traffic on a TURN_CYC=3/MAX_HOLD=5 instance against a behavioural model.
module tb_tbuf_bus_arbiter;

  localparam int N       = 4;
  localparam int B_TURN  = 3;
  localparam int B_HOLD  = 5;
  localparam int STARVE  = N * (B_HOLD + B_TURN);
  localparam int N_RAND  = 10000;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] req_a, req_b;
  logic [3:0] enb_a, enb_b;
  logic [1:0] gnt_a, gnt_b;
  logic       busy_a, busy_b, to_a, to_b;

  tbuf_bus_arbiter #(.N_REQ(N), .TURN_CYC(1), .MAX_HOLD(16)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .enb(enb_a),
    .gnt_id(gnt_a), .bus_busy(busy_a), .timeout(to_a)
  );

  tbuf_bus_arbiter #(.N_REQ(N), .TURN_CYC(B_TURN), .MAX_HOLD(B_HOLD)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .enb(enb_b),
    .gnt_id(gnt_b), .bus_busy(busy_b), .timeout(to_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_a(input logic r, input logic [3:0] q);
    rst_a = r;
    req_a = q;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who owns the bus, how long they have held it, how far
  // into the turnaround gap we are, and which requester has top priority.
  int         m_owner, m_held, m_turn, m_ptr, m_gnt;
  logic [3:0] m_enb;
  logic       m_busy, m_to;

  function automatic int pick(input logic [3:0] q);
    for (int k = 0; k < N; k++)
      if (q[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q);
    int w;
    m_to = 1'b0;
    if (r) begin
      m_owner = -1; m_held = 0; m_turn = 0; m_ptr = 0; m_gnt = 0; m_busy = 1'b0;
    end else if (m_owner >= 0) begin
      if (!q[m_owner] || m_held == B_HOLD) begin
        m_to    = q[m_owner];
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1;
      end else begin
        m_held++;
      end
    end else if (m_turn > 0 && m_turn < B_TURN) begin
      m_turn++;
    end else begin
      w      = pick(q);
      m_turn = 0;
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_gnt = w; m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
    m_enb = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endtask

  initial begin
    logic [3:0] q, prev_enb;
    logic       r, had_owner;
    int         zeros, cyc;
    int         wait_cnt [N];

    rst_a = 1'b1; req_a = '0;
    rst_b = 1'b1; req_b = '0;

    // Reset held with all requests asserted.
    repeat (3) begin
      step_a(1'b1, 4'b1111);
      check("rst_enb", enb_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_gnt", gnt_a, 0);
      check("rst_to", to_a, 0);
    end

    // Single requester 1, released in cycle 5.
    for (int c = 0; c < 9; c++) begin
      step_a(1'b0, (c < 5) ? 4'b0010 : 4'b0000);
      cyc = c + 1;
      check($sformatf("single_enb_c%0d", cyc), enb_a, (cyc <= 5) ? 32'h2 : 32'h0);
      check($sformatf("single_busy_c%0d", cyc), busy_a, (cyc <= 6) ? 32'h1 : 32'h0);
      if (cyc <= 5) check($sformatf("single_gnt_c%0d", cyc), gnt_a, 1);
    end

    // All requesting; each owner drops in its third grant cycle, re-raises next cycle.
    step_a(1'b1, 4'b0000);
    for (int c = 0; c < 20; c++) begin
      q = 4'b1111;
      if (c >= 3 && (c - 3) % 4 == 0) q[((c - 3) / 4) % 4] = 1'b0;
      step_a(1'b0, q);
      cyc = c + 1;
      check($sformatf("rr_enb_c%0d", cyc), enb_a,
            ((cyc - 1) % 4 < 3) ? 32'(1 << (((cyc - 1) / 4) % 4)) : 32'h0);
    end

    // Requester 2 held forever, requester 0 joins at cycle 3: forced off after 16 cycles.
    step_a(1'b1, 4'b0000);
    for (int c = 0; c < 19; c++) begin
      step_a(1'b0, (c >= 3) ? 4'b0101 : 4'b0100);
      cyc = c + 1;
      check($sformatf("hold_enb_c%0d", cyc), enb_a,
            (cyc <= 16) ? 32'h4 : ((cyc == 17) ? 32'h0 : 32'h1));
      check($sformatf("hold_to_c%0d", cyc), to_a, (cyc == 17) ? 32'h1 : 32'h0);
    end

    // Reset while requester 3 owns the bus, then pointer restarts at 0.
    step_a(1'b1, 4'b0000);
    step_a(1'b0, 4'b1000);
    check("midrst_grant", enb_a, 32'h8);
    step_a(1'b1, 4'b1000);
    check("midrst_enb", enb_a, 0);
    check("midrst_busy", busy_a, 0);
    step_a(1'b0, 4'b1001);
    check("midrst_regrant_enb", enb_a, 32'h1);
    check("midrst_regrant_gnt", gnt_a, 0);
    rst_a = 1'b1;

    // Randomized traffic with occasional resets.
    model_step(1'b1, 4'b0000);
    q = '0; prev_enb = '0; had_owner = 1'b0; zeros = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int t = 0; t < N_RAND; t++) begin
      r = (t == 0) || ($urandom_range(99) == 0);
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) q[i] = ~q[i];
      rst_b = r;
      req_b = q;
      model_step(r, q);
      @(posedge clk);
      #1;
      check("rand_enb", enb_b, m_enb);
      check("rand_gnt", gnt_b, m_gnt);
      check("rand_busy", busy_b, m_busy);
      check("rand_to", to_b, m_to);
      check("rand_onehot0", $onehot0(enb_b), 1);

      if (r) begin
        had_owner = 1'b0;
        zeros     = 0;
      end else if (enb_b != 0) begin
        if (prev_enb == 0 && had_owner) check("rand_gap", zeros >= B_TURN, 1);
        had_owner = 1'b1;
        zeros     = 0;
      end else begin
        zeros++;
      end
      prev_enb = enb_b;

      for (int i = 0; i < N; i++) begin
        if (r || !q[i]) begin
          wait_cnt[i] = 0;
        end else if (enb_b[i]) begin
          check($sformatf("rand_starve%0d", i), wait_cnt[i] <= STARVE, 1);
          wait_cnt[i] = 0;
        end else begin
          wait_cnt[i]++;
          if (wait_cnt[i] > STARVE) begin
            check($sformatf("rand_starve%0d", i), wait_cnt[i] <= STARVE, 1);
            wait_cnt[i] = 0;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
